// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared op encodings, FSM states and special-case helper for mul_div_unit
package md_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } md_state_e;

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
  endfunction

  function automatic logic md_is_rem(input md_op_e op);
    return (op == MD_REM) || (op == MD_REMU);
  endfunction

  // Divide by zero (any divide op) or signed overflow (DIV/REM only) skip the iterative datapath.
  function automatic logic md_special(input md_op_e op, input logic b_zero, input logic sovf);
    logic s;
    s = 1'b0;
    if (md_is_div(op)) begin
      if (b_zero) begin
        s = 1'b1;
      end else if (sovf && ((op == MD_DIV) || (op == MD_REM))) begin
        s = 1'b1;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - operand/result handshake bundle between execute stage and mul_div_unit
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output in_valid, op, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, src_a, src_b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative radix-2 RV32M multiply/divide unit
// Shift-add multiply and restoring divide on operand magnitudes; sign fixed up in one extra cycle.
module mul_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  mul_div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  md_op_e             op_q, op_d;
  logic               a_neg_q, a_neg_d;
  logic               b_neg_q, b_neg_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;

  md_op_e           op_in;
  logic             accept;
  logic             b_zero;
  logic             sovf;
  logic             special;
  logic             a_signed_in, b_signed_in;
  logic             a_neg_in, b_neg_in;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;
  logic [WIDTH-1:0] special_res;

  assign op_in       = md_op_e'(bus.op);
  assign accept      = (state_q == S_IDLE) && bus.in_valid && !flush;
  assign b_zero      = (bus.src_b == '0);
  assign sovf        = (bus.src_a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.src_b == '1);
  assign special     = md_special(op_in, b_zero, sovf);

  assign a_signed_in = (op_in == MD_MULH) || (op_in == MD_MULHSU) ||
                       (op_in == MD_DIV)  || (op_in == MD_REM);
  assign b_signed_in = (op_in == MD_MULH) || (op_in == MD_DIV) || (op_in == MD_REM);
  assign a_neg_in    = a_signed_in && bus.src_a[WIDTH-1];
  assign b_neg_in    = b_signed_in && bus.src_b[WIDTH-1];
  assign a_mag_in    = a_neg_in ? (-bus.src_a) : bus.src_a;
  assign b_mag_in    = b_neg_in ? (-bus.src_b) : bus.src_b;

  always_comb begin
    special_res = '0;
    if (b_zero) begin
      special_res = md_is_rem(op_in) ? bus.src_a : '1;
    end else if (op_in == MD_DIV) begin
      special_res = bus.src_a;
    end
  end

  // Multiply: acc = {partial product, remaining multiplier}; shift right each cycle.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  assign mul_sum  = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q})
                             : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, quotient}; shift left and trial-subtract the divisor.
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] div_step;
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign trial    = rem_sh - {1'b0, opnd_q};
  assign div_step = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  logic               op_is_div;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo_mag, rem_mag, quo, rem;
  logic [WIDTH-1:0]   fix_res;

  assign op_is_div = md_is_div(op_q);
  assign prod      = (a_neg_q ^ b_neg_q) ? (-acc_q) : acc_q;
  assign quo_mag   = acc_q[WIDTH-1:0];
  assign rem_mag   = acc_q[2*WIDTH-1:WIDTH];
  assign quo       = (a_neg_q ^ b_neg_q) ? (-quo_mag) : quo_mag;
  assign rem       = a_neg_q ? (-rem_mag) : rem_mag;

  always_comb begin
    fix_res = '0;
    case (op_q)
      MD_MUL:                       fix_res = prod[WIDTH-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod[2*WIDTH-1:WIDTH];
      MD_DIV, MD_DIVU:              fix_res = quo;
      MD_REM, MD_REMU:              fix_res = rem;
      default:                      fix_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (special) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
            cnt_d   = CNT_W'(WIDTH);
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX:  state_d = S_DONE;
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    op_d     = op_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = op_in;
          a_neg_d = a_neg_in;
          b_neg_d = b_neg_in;
          opnd_d  = b_mag_in;
          acc_d   = {{WIDTH{1'b0}}, a_mag_in};
          if (special) begin
            result_d = special_res;
          end
        end
      end
      S_CALC: acc_d = op_is_div ? div_step : mul_step;
      S_FIX: begin
        if (!flush) begin
          result_d = fix_res;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= MD_MUL;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_CALC) || (state_q == S_FIX);
  assign bus.result    = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;
  import md_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_tests;
  int   n_fail;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one op, let it be accepted, wait for out_valid with out_ready high.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res, output int lat);
    bus.op        = op;
    bus.src_a     = a;
    bus.src_b     = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.src_a    = ~a;
    bus.src_b    = a ^ b;
    bus.op       = ~op;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_done"}, {31'd0, bus.out_valid}, 32'd1);
    res = bus.result;
    @(posedge clk); #1;
  endtask

  logic [31:0] res;
  int          lat;
  int          seen;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    flush   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.out_ready = 1'b1;
    #3;
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_busy",      {31'd0, bus.busy},      32'd0);
    check("rst_result",    bus.result,             32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, res, lat);
    check("mul_res", res, 32'hFFFF_FFEB);
    check("mul_lat", lat, 32'd34);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, res, lat);
    check("mulh_res", res, 32'h4000_0000);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    check("mulhu_res", res, 32'hFFFF_FFFE);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    check("mulhsu_res", res, 32'hFFFF_FFFF);

    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, res, lat);
    check("div_res", res, 32'hFFFF_FFFD);
    check("div_lat", lat, 32'd34);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, res, lat);
    check("rem_res", res, 32'hFFFF_FFFF);
    run_op("divu", 3'd5, 32'd100, 32'd7, res, lat);
    check("divu_res", res, 32'd14);
    run_op("remu", 3'd7, 32'd100, 32'd7, res, lat);
    check("remu_res", res, 32'd2);

    run_op("divu0", 3'd5, 32'd5, 32'd0, res, lat);
    check("divu0_res", res, 32'hFFFF_FFFF);
    check("divu0_lat", lat, 32'd1);
    run_op("rem0", 3'd6, 32'd5, 32'd0, res, lat);
    check("rem0_res", res, 32'd5);
    check("rem0_lat", lat, 32'd1);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    check("divovf_res", res, 32'h8000_0000);
    check("divovf_lat", lat, 32'd1);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    check("removf_res", res, 32'd0);
    check("removf_lat", lat, 32'd1);

    // Backpressure on a DIVU 100/7
    bus.op        = 3'd5;
    bus.src_a     = 32'd100;
    bus.src_b     = 32'd7;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_busy", {31'd0, bus.busy}, 32'd1);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_lat", lat, 32'd34);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_result",   bus.result,             32'd14);
      check("bp_in_ready", {31'd0, bus.in_ready},  32'd0);
      check("bp_valid",    {31'd0, bus.out_valid}, 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {31'd0, bus.in_ready}, 32'd1);

    // Flush in IDLE wins over in_valid
    bus.op       = 3'd0;
    bus.src_a    = 32'd3;
    bus.src_b    = 32'd3;
    bus.in_valid = 1'b1;
    flush        = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    check("flush_idle_ready", {31'd0, bus.in_ready}, 32'd1);
    check("flush_idle_busy",  {31'd0, bus.busy},     32'd0);

    // Flush in CALC cycle 5
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("flush_calc_busy", {31'd0, bus.busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_to_idle", {31'd0, bus.in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("flush_no_valid", seen, 32'd0);

    // Reset mid-CALC: result_q holds 14 beforehand, so a cleared result is observable
    bus.op       = 3'd1;
    bus.src_a    = 32'h1234_5678;
    bus.src_b    = 32'h8765_4321;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #1 rst_n = 1'b0;
    #1;
    check("mrst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mrst_busy",      {31'd0, bus.busy},      32'd0);
    check("mrst_result",    bus.result,             32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul67", 3'd0, 32'd6, 32'd7, res, lat);
    check("mul67_res", res, 32'd42);
    check("mul67_lat", lat, 32'd34);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide unit, parametrised in WIDTH, placed beside the combinational ALU in the execute stage.
- Radix-2 datapath: shift-add for multiply, restoring division for divide; one bit per cycle.
- Operands arrive and results leave over valid/ready handshakes, so the pipeline can stall on busy.
- Divide-by-zero and signed overflow follow RISC-V semantics and complete on a 1-cycle fast path.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and >= 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort of any in-flight operation.
- in_valid  input  1  operand/op valid.
- in_ready  output  1  unit can accept; high only in IDLE.
- op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- src_a  input  WIDTH  rs1 operand (multiplicand/dividend).
- src_b  input  WIDTH  rs2 operand (multiplier/divisor).
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  result; held stable while out_valid=1 and out_ready=0.
- busy  output  1  high in CALC or FIX.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, counter=0, all datapath registers cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE, normal accept (in_valid & in_ready):
  - Latch op; record sign flags: MULH, DIV and REM treat both operands as signed; MULHSU treats src_a only as signed.
  - Store operand magnitudes; clear the 2*WIDTH accumulator; counter=WIDTH; go to CALC.
- IDLE, special cases (accept goes straight to DONE, result registered):
  - DIV/DIVU with src_b=0: result = all ones.
  - REM/REMU with src_b=0: result = src_a.
  - DIV with src_a = 1 followed by WIDTH-1 zeros and src_b = all ones: result = src_a.
  - REM in the same overflow case: result = 0.
- CALC: one iteration per cycle; counter decrements; when counter reaches 1, the next state is FIX. CALC lasts exactly WIDTH cycles.
  - Multiply: if the current multiplier LSB is 1, add the multiplicand magnitude to the upper accumulator half; then shift right 1.
  - Divide: shift remainder:quotient left 1; trial-subtract the divisor; if non-negative, keep the difference and set quotient LSB=1.
- FIX (1 cycle): apply sign correction and select the output; register result; go to DONE.
  - Negate the product if the operand signs differ.
  - Negate the quotient if the dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - MUL returns product[WIDTH-1:0]; MULH/MULHSU/MULHU return product[2*WIDTH-1:WIDTH].
- DONE: out_valid=1; on out_ready go to IDLE. No new op is accepted in the same cycle (in_ready=0 in DONE).
- Latency from the accept edge to out_valid: WIDTH+2 cycles for normal ops, 1 cycle for special cases.
- flush:
  - In CALC, FIX or DONE: go to IDLE next cycle; out_valid=0; result discarded.
  - In IDLE: flush has priority over in_valid, so nothing is accepted that cycle.
- Inputs are ignored outside IDLE. src_a, src_b and op changing mid-operation have no effect.
- Reset asserted mid-operation: immediate return to reset values; no partial result is ever presented.
- All arithmetic is unsigned on magnitudes of width WIDTH+1 (trial subtract) or 2*WIDTH (product). Negation is two's complement within the target width.

Decomposition:
- Shared package md_pkg holds:
  - op encodings MD_MUL..MD_REMU;
  - state enum {S_IDLE, S_CALC, S_FIX, S_DONE};
  - a function returning the special-case flag.
- No sub-module is natural. Keep a single module: one FSM process, one datapath process, combinational sign/negate logic.

Test Plan:
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD), out_ready=1 -> result 0xFFFFFFEB, out_valid exactly 34 cycles after accept.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0. Each gives out_valid 1 cycle after accept.
- Backpressure: out_ready held 0 for 10 cycles -> result stable and in_ready=0 throughout; out_ready=1 -> in_ready=1 next cycle.
- Flush in CALC cycle 5 -> IDLE next cycle, out_valid never rises. Then rst_n low mid-CALC -> all outputs at reset values immediately. A subsequent MUL 6x7 returns 42.
